// File: rtl/sort_stream_host.sv
// -----------------------------------------------------------------------------
// sort_stream_host
//
// Host-side driver for an N-bit, 2^L-entry sorter. Accepts exactly 2^L words
// on a valid/ready slave port, writes them into sorter memory through the
// WrInit port, pulses start, waits for done, then reads all 2^L entries back
// in address order and presents them on a valid/ready master port, marking
// the final word (address 2^L-1) with m_last.
//
// Parameters:
//   N            data word width (must match sorter)
//   L            address width, block size 2^L words (must match sorter)
//   TIMEOUT_CYC  watchdog limit in WAIT cycles (watchdog build only)
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   s_valid/s_data/s_ready    unsorted input stream (slave)
//   m_valid/m_data/m_last/    sorted output stream (master), m_last on the
//   m_ready                   final word of the block
//   srt_wrinit/srt_datain     sorter memory write strobe and data
//   srt_rd                    sorter memory read strobe
//   srt_raddr                 sorter memory address (always the word counter)
//   srt_start                 one-cycle sorter start pulse
//   srt_dataout/srt_done      sorter read data (valid the cycle after srt_rd)
//                             and completion flag (pulse or level)
//   busy                      high whenever not IDLE
//   err                       sticky watchdog timeout flag
//
// Build option:
//   SORT_HOST_WATCHDOG_EN  when defined, a counter runs in WAIT; if done is not
//                          seen within TIMEOUT_CYC cycles, err is set (sticky
//                          until reset) and the block returns to IDLE without
//                          readback. When undefined, err is tied low and WAIT
//                          waits indefinitely.
// -----------------------------------------------------------------------------
module sort_stream_host #(
    parameter int N           = 16,
    parameter int L           = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [N-1:0] s_data,
    output logic         s_ready,
    output logic         m_valid,
    output logic [N-1:0] m_data,
    output logic         m_last,
    input  logic         m_ready,
    output logic         srt_wrinit,
    output logic         srt_rd,
    output logic [L-1:0] srt_raddr,
    output logic [N-1:0] srt_datain,
    output logic         srt_start,
    input  logic [N-1:0] srt_dataout,
    input  logic         srt_done,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        READ,
        PRESENT
    } state_t;

    state_t       state;
    logic [L-1:0] cnt;
    // Set on entry to WAIT so a done level left over from a previous run is
    // not mistaken for completion of this one.
    logic         wait_first;

`ifdef SORT_HOST_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
    logic            err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Strobes decode directly from the state register.
    assign s_ready    = (state == LOAD);
    assign srt_wrinit = (state == LOAD) && s_valid;
    assign srt_datain = s_data;
    assign srt_raddr  = cnt;
    assign srt_start  = (state == START);
    assign srt_rd     = (state == READ);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wait_first <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
`ifdef SORT_HOST_WATCHDOG_EN
            wd         <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // One bubble cycle: nothing is consumed here.
                    if (s_valid) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    state      <= WAIT;
                    wait_first <= 1'b1;
`ifdef SORT_HOST_WATCHDOG_EN
                    wd         <= '0;
`endif
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    if (!wait_first && srt_done) begin
                        state <= READ;
                        cnt   <= '0;
                    end
`ifdef SORT_HOST_WATCHDOG_EN
                    else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                READ: begin
                    state <= PRESENT;
                end
                PRESENT: begin
                    // m_valid low marks the capture cycle: sorter data from
                    // the preceding READ is valid now.
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= srt_dataout;
                        m_last  <= (cnt == '1);
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= READ;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_stream_host.sv
module tb_sort_stream_host;

    typedef logic [15:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        srt_wrinit;
    logic        srt_rd;
    logic [3:0]  srt_raddr;
    logic [15:0] srt_datain;
    logic        srt_start;
    logic [15:0] srt_dataout = '0;
    logic        srt_done = 1'b0;
    logic        busy;
    logic        err;

    int vec  = 0;
    int errs = 0;

    sort_stream_host #(
        .N(16),
        .L(4),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_ready(m_ready),
        .srt_wrinit(srt_wrinit),
        .srt_rd(srt_rd),
        .srt_raddr(srt_raddr),
        .srt_datain(srt_datain),
        .srt_start(srt_start),
        .srt_dataout(srt_dataout),
        .srt_done(srt_done),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- sorter model ----------------
    logic [15:0] mem    [16];
    logic [15:0] sorted [16];
    int          dly = 0;
    bit          stale_mode = 1'b0;
    bit          never_done = 1'b0;

    function automatic blk_t sort16(input blk_t a);
        blk_t        r;
        logic [15:0] t;
        r = a;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    always @(posedge clk) begin
        if (srt_wrinit) mem[srt_raddr] <= srt_datain;
        if (srt_rd) srt_dataout <= sorted[srt_raddr];
        if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) srt_done <= 1'b1;
        end
        if (srt_start) begin
            sorted <= sort16(mem);
            if (!stale_mode) srt_done <= 1'b0;
            dly <= never_done ? 0 : 5;
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    int          cyc = 0, wr_cnt = 0, addr_err = 0, start_cnt = 0, start_cyc = 0;
    int          rd_cnt = 0, first_rd_cyc = 0, overlap = 0, out_cnt = 0;
    logic [15:0] out_data [16];
    logic        out_last [16];

    always @(negedge clk) begin
        cyc++;
        if (srt_wrinit) begin
            if (srt_raddr !== 4'(wr_cnt)) addr_err++;
            wr_cnt++;
        end
        if (srt_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (srt_rd) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
        end
        if (srt_wrinit && srt_rd) overlap++;
        if (m_valid && m_ready) begin
            if (out_cnt < 16) begin
                out_data[out_cnt] = m_data;
                out_last[out_cnt] = m_last;
            end
            out_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_mon();
        wr_cnt = 0; addr_err = 0; start_cnt = 0; rd_cnt = 0;
        overlap = 0; out_cnt = 0; start_cyc = 0; first_rd_cyc = 0;
    endtask

    task automatic load_block(input blk_t w, input bit thr, output bit ok);
        bit hs;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = w[i];
            hs      = 1'b0;
            for (int k = 0; k < 200 && !hs; k++) begin
                @(negedge clk);
                hs = s_valid && s_ready;
                @(posedge clk); #1;
            end
            if (!hs) ok = 1'b0;
            if (thr) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (!busy && out_cnt >= 16) ok = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_out_cnt(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge clk); #1;
            if (out_cnt == n) ok = 1'b1;
        end
    endtask

    task automatic wait_mvalid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (m_valid) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
        vec++; if (m_last !== 1'b0) begin errs++; $display("FAIL rst_m_last got %b exp 0", m_last); end
        vec++; if (m_data !== 16'h0000) begin errs++; $display("FAIL rst_m_data got %h exp 0000", m_data); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", busy); end
        vec++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err got %b exp 0", err); end
        vec++; if (srt_start !== 1'b0 || srt_rd !== 1'b0 || s_ready !== 1'b0)
            begin errs++; $display("FAIL rst_strobes got start=%b rd=%b s_ready=%b exp 0", srt_start, srt_rd, s_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        blk_t w;
        bit   ok;
        for (int i = 0; i < 16; i++) w[i] = 16'(15 - i);
        clear_mon();
        load_block(w, 1'b0, ok);
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL basic_load_timeout got %b exp 1", ok); end
        wait_idle(ok);
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL basic_idle_timeout got %b exp 1", ok); end
        vec++; if (wr_cnt !== 16) begin errs++; $display("FAIL basic_wr_cnt got %0d exp 16", wr_cnt); end
        vec++; if (addr_err !== 0) begin errs++; $display("FAIL basic_wr_addr got %0d bad exp 0", addr_err); end
        vec++; if (start_cnt !== 1) begin errs++; $display("FAIL basic_start_cnt got %0d exp 1", start_cnt); end
        vec++; if (first_rd_cyc - start_cyc !== 7) begin errs++; $display("FAIL basic_done_latency got %0d exp 7", first_rd_cyc - start_cyc); end
        vec++; if (out_cnt !== 16) begin errs++; $display("FAIL basic_out_cnt got %0d exp 16", out_cnt); end
        for (int i = 0; i < 16; i++) begin
            vec++; if (out_data[i] !== 16'(i)) begin errs++; $display("FAIL basic_data[%0d] got %h exp %h", i, out_data[i], 16'(i)); end
            vec++; if (out_last[i] !== (i == 15)) begin errs++; $display("FAIL basic_last[%0d] got %b exp %b", i, out_last[i], (i == 15)); end
        end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_throttle();
        blk_t w;
        bit   ok;
        for (int i = 0; i < 16; i++) w[i] = 16'hFFF0 | 16'((i * 7) % 16);
        clear_mon();
        load_block(w, 1'b1, ok);
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL thr_load_timeout got %b exp 1", ok); end
        wait_idle(ok);
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL thr_idle_timeout got %b exp 1", ok); end
        vec++; if (wr_cnt !== 16) begin errs++; $display("FAIL thr_wr_cnt got %0d exp 16", wr_cnt); end
        vec++; if (addr_err !== 0) begin errs++; $display("FAIL thr_wr_addr got %0d bad exp 0", addr_err); end
        vec++; if (overlap !== 0) begin errs++; $display("FAIL thr_wr_rd_overlap got %0d exp 0", overlap); end
        for (int a = 0; a < 16; a++) begin
            vec++; if (mem[a] !== (16'hFFF0 | 16'((a * 7) % 16))) begin errs++; $display("FAIL thr_mem[%0d] got %h exp %h", a, mem[a], 16'hFFF0 | 16'((a * 7) % 16)); end
        end
        for (int i = 0; i < 16; i++) begin
            vec++; if (out_data[i] !== 16'hFFF0 + 16'(i)) begin errs++; $display("FAIL thr_data[%0d] got %h exp %h", i, out_data[i], 16'hFFF0 + 16'(i)); end
        end
    endtask

    task automatic test_stall();
        blk_t w;
        bit   ok;
        for (int i = 0; i < 16; i++) w[i] = 16'(15 - i);
        clear_mon();
        m_ready = 1'b1;
        load_block(w, 1'b0, ok);
        wait_out_cnt(3, ok);
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL stall_reach3 got %b exp 1", ok); end
        m_ready = 1'b0;
        wait_mvalid(ok);
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL stall_mvalid_timeout got %b exp 1", ok); end
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            vec++; if (m_valid !== 1'b1 || m_data !== 16'h0003)
                begin errs++; $display("FAIL stall_hold[%0d] got v=%b d=%h exp v=1 d=0003", k, m_valid, m_data); end
            vec++; if (srt_rd !== 1'b0) begin errs++; $display("FAIL stall_no_rd[%0d] got %b exp 0", k, srt_rd); end
        end
        vec++; if (rd_cnt !== 4) begin errs++; $display("FAIL stall_rd_cnt got %0d exp 4", rd_cnt); end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle(ok);
        vec++; if (out_cnt !== 16 || rd_cnt !== 16) begin errs++; $display("FAIL stall_counts got out=%0d rd=%0d exp 16/16", out_cnt, rd_cnt); end
        for (int i = 0; i < 16; i++) begin
            vec++; if (out_data[i] !== 16'(i)) begin errs++; $display("FAIL stall_data[%0d] got %h exp %h", i, out_data[i], 16'(i)); end
        end
    endtask

    task automatic test_stale_done();
        blk_t w;
        bit   ok;
        for (int i = 0; i < 16; i++) w[i] = 16'h1000 + 16'(15 - i);
        vec++; if (srt_done !== 1'b1) begin errs++; $display("FAIL stale_pre_done got %b exp 1", srt_done); end
        stale_mode = 1'b1;
        clear_mon();
        load_block(w, 1'b0, ok);
        wait_idle(ok);
        stale_mode = 1'b0;
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL stale_idle_timeout got %b exp 1", ok); end
        vec++; if (first_rd_cyc - start_cyc !== 3) begin errs++; $display("FAIL stale_rd_latency got %0d exp 3", first_rd_cyc - start_cyc); end
        for (int i = 0; i < 16; i++) begin
            vec++; if (out_data[i] !== 16'h1000 + 16'(i)) begin errs++; $display("FAIL stale_data[%0d] got %h exp %h", i, out_data[i], 16'h1000 + 16'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        blk_t w;
        bit   ok;
        for (int i = 0; i < 16; i++) w[i] = 16'(15 - i);
        clear_mon();
        load_block(w, 1'b0, ok);
        wait_out_cnt(7, ok);
        m_ready = 1'b0;
        wait_mvalid(ok);
        vec++; if (ok !== 1'b1 || m_data !== 16'h0007) begin errs++; $display("FAIL rmid_word7 got ok=%b d=%h exp ok=1 d=0007", ok, m_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vec++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rmid_m_valid got %b exp 0", m_valid); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b exp 0", busy); end
        vec++; if (out_cnt !== 7) begin errs++; $display("FAIL rmid_out_cnt got %0d exp 7", out_cnt); end
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) w[i] = 16'h0200 + 16'((i * 5) % 16);
        clear_mon();
        load_block(w, 1'b0, ok);
        wait_idle(ok);
        vec++; if (ok !== 1'b1 || wr_cnt !== 16 || start_cnt !== 1)
            begin errs++; $display("FAIL rmid_next_block got ok=%b wr=%0d start=%0d exp 1/16/1", ok, wr_cnt, start_cnt); end
        for (int i = 0; i < 16; i++) begin
            vec++; if (out_data[i] !== 16'h0200 + 16'(i)) begin errs++; $display("FAIL rmid_data[%0d] got %h exp %h", i, out_data[i], 16'h0200 + 16'(i)); end
            vec++; if (out_last[i] !== (i == 15)) begin errs++; $display("FAIL rmid_last[%0d] got %b exp %b", i, out_last[i], (i == 15)); end
        end
    endtask

    task automatic test_watchdog();
        blk_t w;
        bit   ok;
        for (int i = 0; i < 16; i++) w[i] = 16'(15 - i);
        never_done = 1'b1;
        clear_mon();
        load_block(w, 1'b0, ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (srt_start) ok = 1'b1;
        end
        vec++; if (ok !== 1'b1) begin errs++; $display("FAIL wd_start_timeout got %b exp 1", ok); end
        repeat (20) @(negedge clk);
        vec++; if (busy !== 1'b1 || err !== 1'b0) begin errs++; $display("FAIL wd_wait20 got busy=%b err=%b exp 1/0", busy, err); end
        @(negedge clk);
`ifdef SORT_HOST_WATCHDOG_EN
        vec++; if (err !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL wd_timeout got err=%b busy=%b exp 1/0", err, busy); end
`else
        vec++; if (err !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL wd_no_timeout got err=%b busy=%b exp 0/1", err, busy); end
`endif
        repeat (10) @(negedge clk);
        vec++; if (rd_cnt !== 0) begin errs++; $display("FAIL wd_no_rd got %0d exp 0", rd_cnt); end
        @(posedge clk); #1;
        never_done = 1'b0;
`ifdef SORT_HOST_WATCHDOG_EN
        clear_mon();
        load_block(w, 1'b0, ok);
        wait_idle(ok);
        vec++; if (ok !== 1'b1 || out_data[15] !== 16'h000F || err !== 1'b1)
            begin errs++; $display("FAIL wd_after_err got ok=%b d15=%h err=%b exp 1/000f/1", ok, out_data[15], err); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vec++; if (err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL wd_reset_clear got err=%b busy=%b exp 0/0", err, busy); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throttle();
        test_stall();
        test_stale_done();
        test_reset_mid();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/sort_stream_host.md
Name: sort_stream_host

Overview:
- Host-side driver for the N-bit, 2^L-entry sorter: the other end of the sorter's load / start / done / readback interface.
- Accepts an unsorted stream of exactly 2^L words on a valid/ready slave port and writes them into sorter memory via WrInit.
- Pulses start, waits for done, then reads all 2^L entries back in address order and emits them on a valid/ready master port with a last flag.
- Sits between a stream source/sink and the sorter top.

Parameters:
N, 16, data word width (must match sorter N)
L, 4, address width; block size is 2^L words (must match sorter L)
TIMEOUT_CYC, 4096, watchdog limit in cycles for the sorter run (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
s_valid  in  1  input word valid
s_data  in  N  input word
s_ready  out  1  input word accepted when s_valid && s_ready
m_valid  out  1  output word valid
m_data  out  N  output word (sorted order)
m_last  out  1  marks final word of block (address 2^L-1)
m_ready  in  1  sink accepts when m_valid && m_ready
srt_wrinit  out  1  sorter memory write strobe (to WrInit)
srt_rd  out  1  sorter memory read strobe (to Rd)
srt_raddr  out  L  sorter memory address (to RAddr)
srt_datain  out  N  sorter write data (to DataIn)
srt_start  out  1  one-cycle sorter start pulse
srt_dataout  in  N  sorter read data (from DataOut)
srt_done  in  1  sorter done (from done)
busy  out  1  high whenever state != IDLE
err  out  1  sticky watchdog error (optional feature)

Behaviour:
- Reset (rst=0 at a clock edge):
  - state IDLE, address counter cnt=0.
  - m_valid, m_data, m_last, srt_start, srt_rd, busy, err all 0.
  - Reset mid-operation aborts the run: no start pulse issued, in-flight output dropped.
- States: IDLE, LOAD, START, WAIT, READ, PRESENT.
- IDLE:
  - s_ready=0.
  - s_valid=1 -> LOAD with cnt=0. This costs one bubble cycle; no word is consumed in IDLE.
- LOAD:
  - s_ready=1.
  - srt_wrinit = s_valid & s_ready, combinational.
  - srt_datain = s_data; srt_raddr = cnt.
  - Each handshake increments cnt.
  - Handshake at cnt=2^L-1 -> START; cnt wraps to 0.
  - s_valid low stalls LOAD indefinitely with no write.
- START:
  - srt_start=1 for exactly this one cycle; s_ready=0.
  - Next state WAIT; watchdog counter cleared.
- WAIT:
  - srt_done is ignored in the first WAIT cycle (guards against a stale done level held from a previous run).
  - From the second WAIT cycle on, srt_done=1 -> READ with cnt=0.
  - srt_done may be a pulse or a level; the first sampled high is used.
- READ:
  - srt_rd=1, srt_raddr=cnt, for one cycle.
  - Sorter read data is valid the following cycle.
  - Next state PRESENT.
- PRESENT:
  - First cycle: m_data is registered from srt_dataout; m_valid=1; m_last=(cnt==2^L-1).
  - m_data and m_last are held stable while m_valid && !m_ready.
  - On handshake, m_valid drops next cycle:
    - if m_last -> IDLE, cnt=0;
    - else cnt+1 and -> READ.
  - Maximum throughput is one output word per 3 cycles: READ, capture, handshake.
- srt_wrinit and srt_rd are never high in the same cycle; srt_raddr = cnt in all states.
- s_valid asserted outside LOAD is not consumed; the next block begins only after returning to IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro SORT_HOST_WATCHDOG_EN defined:
  - A counter runs in WAIT.
  - If srt_done is not seen within TIMEOUT_CYC cycles: err is set (sticky until reset), state -> IDLE, no readback.
  - err=1 does not block new blocks.
- Macro undefined: no counter is built, err is tied 0, and WAIT waits indefinitely.

Test Plan:
- N=16, L=4; stream 16 words 15..0 with m_ready=1; sorter model sorts ascending -> srt_wrinit pulses 16 times at addrs 0..15, exactly one srt_start, then m_data 0,1,..,15 in order with m_last only on word 15, then busy=0.
- Throttle s_valid low every other cycle during load -> writes occur only on handshake cycles; addresses remain contiguous 0..15; no extra or missing writes.
- Hold m_ready=0 for 5 cycles on word 3 -> m_valid stays 1 and m_data stays at word 3 value; no srt_rd issued until handshake.
- Sorter model holds done=1 from the previous run into the new START -> block ignores done in the first WAIT cycle and enters READ only on done sampled in cycle 2 or later.
- Deassert rst for one cycle while in PRESENT at word 7 -> next cycle m_valid=0, busy=0, state IDLE; a following full block completes correctly.
- With SORT_HOST_WATCHDOG_EN and TIMEOUT_CYC=20, sorter never asserts done -> err=1 after 20 WAIT cycles, state IDLE, no srt_rd; without the macro, err stays 0.
